// File: rtl/gameover_banner_ctrl.sv
// gameover_banner_ctrl
// Sequencer for the game-over banner bitmap. A gameOver pulse makes the
// banner slide down from START_Y to TARGET_Y, blink BLINK_TOGGLES times, and
// then hold until the player presses restart. Every cycle it turns the VGA
// pixel coordinate into the banner bitmap's rectangle-hit and offset inputs.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   startOfFrame      one-cycle pulse at the start of each frame
//   gameOver          one-cycle pulse from the game-state logic (IDLE only)
//   keyRestart        debounced restart key level
//   pixelX, pixelY    current VGA pixel coordinate (11 bits)
//   InsideRectangle   registered: pixel is inside the visible banner
//   offsetX, offsetY  registered: pixel offset into the banner, 0 when outside
//   restartReq        one-cycle restart request to the game-state logic
//   bannerActive      high in every state except IDLE
module gameover_banner_ctrl #(
    parameter int BANNER_X      = 250,
    parameter int START_Y       = 0,
    parameter int TARGET_Y      = 228,
    parameter int SLIDE_STEP    = 4,
    parameter int BANNER_W      = 140,
    parameter int BANNER_H      = 24,
    parameter int BLINK_FRAMES  = 15,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        gameOver,
    input  logic        keyRestart,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        restartReq,
    output logic        bannerActive
);

    typedef enum logic [2:0] {
        IDLE,
        SLIDE,
        BLINK,
        HOLD,
        RESTART
    } state_t;

    // Bounds are 12 bits wide so that pixel + size never wraps.
    localparam logic [10:0] X_LO        = 11'(BANNER_X);
    localparam logic [11:0] X_HI        = 12'(BANNER_X + BANNER_W);
    localparam logic [10:0] Y_START     = 11'(START_Y);
    localparam logic [11:0] Y_TARGET    = 12'(TARGET_Y);
    localparam logic [11:0] STEP        = 12'(SLIDE_STEP);
    localparam logic [11:0] HEIGHT      = 12'(BANNER_H);
    localparam logic [7:0]  FRAME_LAST  = 8'(BLINK_FRAMES - 1);
    localparam logic [3:0]  TOGGLE_LAST = 4'(BLINK_TOGGLES - 1);

    state_t      state;
    logic [10:0] banner_y;
    logic [7:0]  frame_cnt;
    logic [3:0]  toggle_cnt;
    logic        visible;
    logic        armed;
    logic        key_d;

    logic [11:0] slide_sum;
    logic [11:0] y_hi;
    logic        key_rise;
    logic        hit;

    always_comb begin
        slide_sum = {1'b0, banner_y} + STEP;
        y_hi      = {1'b0, banner_y} + HEIGHT;
        key_rise  = keyRestart & ~key_d;
        hit       = visible && (state != IDLE) &&
                    (pixelX >= X_LO) && ({1'b0, pixelX} < X_HI) &&
                    (pixelY >= banner_y) && ({1'b0, pixelY} < y_hi);
    end

    // Sequencer. bannerY only ever moves on a startOfFrame cycle so the
    // banner cannot tear in the middle of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            banner_y     <= Y_START;
            frame_cnt    <= 8'd0;
            toggle_cnt   <= 4'd0;
            visible      <= 1'b0;
            armed        <= 1'b0;
            key_d        <= 1'b0;
            restartReq   <= 1'b0;
            bannerActive <= 1'b0;
        end else begin
            key_d      <= keyRestart;
            restartReq <= 1'b0;
            case (state)
                IDLE: begin
                    // A startOfFrame coinciding with gameOver is not counted.
                    if (gameOver) begin
                        state        <= SLIDE;
                        banner_y     <= Y_START;
                        frame_cnt    <= 8'd0;
                        toggle_cnt   <= 4'd0;
                        visible      <= 1'b1;
                        armed        <= 1'b0;
                        bannerActive <= 1'b1;
                    end
                end
                SLIDE: begin
                    if (startOfFrame) begin
                        if (slide_sum >= Y_TARGET) begin
                            // Clamp: never overshoot the target row.
                            banner_y   <= Y_TARGET[10:0];
                            frame_cnt  <= 8'd0;
                            toggle_cnt <= 4'd0;
                            visible    <= 1'b1;
                            state      <= BLINK;
                        end else begin
                            banner_y <= slide_sum[10:0];
                        end
                    end
                end
                BLINK: begin
                    if (startOfFrame) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt  <= 8'd0;
                            toggle_cnt <= toggle_cnt + 4'd1;
                            if (toggle_cnt == TOGGLE_LAST) begin
                                // Last toggle: always finish visible.
                                visible <= 1'b1;
                                armed   <= 1'b0;
                                state   <= HOLD;
                            end else begin
                                visible <= ~visible;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                HOLD: begin
                    // A key held since the animation must be released
                    // (seen low) before a press counts.
                    if (!keyRestart) armed <= 1'b1;
                    if (armed && key_rise) begin
                        state      <= RESTART;
                        restartReq <= 1'b1;
                    end
                end
                RESTART: begin
                    state        <= IDLE;
                    visible      <= 1'b0;
                    armed        <= 1'b0;
                    bannerActive <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered rectangle mapping; offsets are zeroed outside the banner so
    // the bitmap never indexes out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            InsideRectangle <= 1'b0;
            offsetX         <= 11'd0;
            offsetY         <= 11'd0;
        end else begin
            InsideRectangle <= hit;
            offsetX         <= hit ? (pixelX - X_LO)     : 11'd0;
            offsetY         <= hit ? (pixelY - banner_y) : 11'd0;
        end
    end

endmodule

// File: tb/tb_gameover_banner_ctrl.sv
// Bench for gameover_banner_ctrl. Stimulus issues pixel probes and pushes the
// expected registered outputs into a queue; a monitor pops and compares one
// cycle later. A second instance with TARGET_Y = 10 covers the slide clamp.
module tb_gameover_banner_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        gameOver = 1'b0;
    logic        keyRestart = 1'b0;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] pixelY = 11'd0;

    logic        ins, rr, ba;
    logic [10:0] ox, oy;
    logic        s_ins, s_rr, s_ba;
    logic [10:0] s_ox, s_oy;

    gameover_banner_ctrl u_dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .gameOver(gameOver), .keyRestart(keyRestart),
        .pixelX(pixelX), .pixelY(pixelY),
        .InsideRectangle(ins), .offsetX(ox), .offsetY(oy),
        .restartReq(rr), .bannerActive(ba)
    );

    gameover_banner_ctrl #(.TARGET_Y(10)) u_small (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .gameOver(gameOver), .keyRestart(keyRestart),
        .pixelX(pixelX), .pixelY(pixelY),
        .InsideRectangle(s_ins), .offsetX(s_ox), .offsetY(s_oy),
        .restartReq(s_rr), .bannerActive(s_ba)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic        ei;
        logic [10:0] eox;
        logic [10:0] eoy;
        logic        ea;
        logic        er;
        logic        cs;
        logic        si;
        logic [10:0] sox;
        logic [10:0] soy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   tag_n = 0;
    logic probe = 1'b0;
    logic probe_d = 1'b0;

    always @(posedge clk) probe_d <= probe;

    // Monitor: the output registered from a probed pixel is visible after the
    // following rising edge, so compare on the falling edge.
    always @(negedge clk) begin
        if (probe_d) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_underflow: output seen with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                total++;
                if ({ins, ox, oy, ba, rr} !== {mon_e.ei, mon_e.eox, mon_e.eoy, mon_e.ea, mon_e.er}) begin
                    bad++;
                    $display("FAIL probe%0d main: got ins=%0b ox=%0d oy=%0d act=%0b req=%0b want ins=%0b ox=%0d oy=%0d act=%0b req=%0b",
                             mon_e.tag, ins, ox, oy, ba, rr, mon_e.ei, mon_e.eox, mon_e.eoy, mon_e.ea, mon_e.er);
                end
                if (mon_e.cs) begin
                    total++;
                    if ({s_ins, s_ox, s_oy} !== {mon_e.si, mon_e.sox, mon_e.soy}) begin
                        bad++;
                        $display("FAIL probe%0d small: got ins=%0b ox=%0d oy=%0d want ins=%0b ox=%0d oy=%0d",
                                 mon_e.tag, s_ins, s_ox, s_oy, mon_e.si, mon_e.sox, mon_e.soy);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    task automatic pulse_go();
        gameOver = 1'b1;
        step();
        gameOver = 1'b0;
    endtask

    task automatic probe_full(input int x, input int y, input bit ei, input int eox,
                              input int eoy, input bit ea, input bit er, input bit cs,
                              input bit si, input int sox, input int soy);
        exp_t e;
        e.tag = tag_n;
        tag_n++;
        e.ei = ei; e.eox = 11'(eox); e.eoy = 11'(eoy); e.ea = ea; e.er = er;
        e.cs = cs; e.si = si; e.sox = 11'(sox); e.soy = 11'(soy);
        sb.push_back(e);
        pixelX = 11'(x);
        pixelY = 11'(y);
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    task automatic probe_m(input int x, input int y, input bit ei, input int eox,
                           input int eoy, input bit ea, input bit er);
        probe_full(x, y, ei, eox, eoy, ea, er, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        probe_full(250, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Reset mid-animation
        pulse_go();
        probe_full(250, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        for (int f = 0; f < 10; f++) frame();
        probe_m(250, 40, 1, 0, 0, 1, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        probe_full(250, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        probe_m(250, 40, 0, 0, 0, 0, 0);

        // gameOver together with startOfFrame: that frame is not counted
        gameOver = 1'b1;
        startOfFrame = 1'b1;
        step();
        gameOver = 1'b0;
        startOfFrame = 1'b0;
        probe_full(250, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        probe_m(250, 23, 1, 0, 23, 1, 0);
        probe_m(250, 24, 0, 0, 0, 1, 0);

        // Slide: main steps 4 px per frame to 228; small clamps 4, 8, 10
        for (int k = 1; k <= 57; k++) begin
            frame();
            case (k)
                1: probe_full(250, 4, 1, 0, 0, 1, 0, 1, 1, 0, 0);
                2: probe_full(250, 8, 1, 0, 0, 1, 0, 1, 1, 0, 0);
                3: begin
                    probe_full(250, 12, 1, 0, 0, 1, 0, 1, 1, 0, 2);
                    probe_full(250, 10, 0, 0, 0, 1, 0, 1, 1, 0, 0);
                    probe_full(250, 9, 0, 0, 0, 1, 0, 1, 0, 0, 0);
                    probe_full(250, 33, 1, 0, 21, 1, 0, 1, 1, 0, 23);
                end
                4: begin
                    probe_full(250, 16, 1, 0, 0, 1, 0, 1, 1, 0, 6);
                    probe_full(250, 10, 0, 0, 0, 1, 0, 1, 1, 0, 0);
                end
                default: probe_m(250, 4 * k, 1, 0, 0, 1, 0);
            endcase
            if (k == 10) begin
                // gameOver ignored in SLIDE: bannerY stays at 40
                pulse_go();
                probe_m(250, 40, 1, 0, 0, 1, 0);
                probe_m(250, 0, 0, 0, 0, 1, 0);
            end
            if (k == 20) begin
                probe_m(300, 103, 1, 50, 23, 1, 0);
                probe_m(300, 104, 0, 0, 0, 1, 0);
                probe_m(300, 79, 0, 0, 0, 1, 0);
            end
        end

        // Blink: toggles every 15 frames, 6 toggles, HOLD visible at frame 90
        for (int k = 1; k <= 90; k++) begin
            if (k == 80) keyRestart = 1'b1;
            frame();
            probe_m(250, 228, ((k / 15) % 2) == 0, 0, 0, 1, 0);
        end

        // HOLD with key still held from BLINK: mapping, no restart
        probe_m(250, 228, 1, 0, 0, 1, 0);
        probe_m(389, 251, 1, 139, 23, 1, 0);
        probe_m(249, 228, 0, 0, 0, 1, 0);
        probe_m(390, 228, 0, 0, 0, 1, 0);
        probe_m(250, 227, 0, 0, 0, 1, 0);
        probe_m(250, 252, 0, 0, 0, 1, 0);

        // gameOver ignored in HOLD
        pulse_go();
        frame();
        probe_m(250, 228, 1, 0, 0, 1, 0);
        probe_m(250, 4, 0, 0, 0, 1, 0);

        // Release, then press: one-cycle restartReq, then IDLE
        keyRestart = 1'b0;
        probe_m(0, 0, 0, 0, 0, 1, 0);
        probe_m(0, 0, 0, 0, 0, 1, 0);
        keyRestart = 1'b1;
        probe_m(250, 228, 1, 0, 0, 1, 1);
        probe_m(250, 228, 1, 0, 0, 0, 0);
        probe_m(250, 228, 0, 0, 0, 0, 0);
        keyRestart = 1'b0;
        probe_m(250, 228, 0, 0, 0, 0, 0);

        // A fresh gameOver starts again from the top
        pulse_go();
        probe_m(250, 0, 1, 0, 0, 1, 0);
        probe_m(250, 228, 0, 0, 0, 1, 0);

        step(); step(); step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
